// File: rtl/alu_result_fifo.sv
// Four-entry FIFO capturing ALU results with derived {C,Z,N,CMP} flags.
// Optional same-cycle bypass when empty: define ALU_FIFO_BYPASS_EN.
module alu_result_fifo (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] alu_out,
   input  logic        carry_out,
   input  logic        compare,
   input  logic        mode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic [3:0]  out_flags,
   output logic [2:0]  count
);

   logic [15:0] r_data [4];
   logic [3:0]  r_flag [4];
   logic [1:0]  r_rd_ptr;
   logic [1:0]  r_wr_ptr;
   logic [2:0]  r_count;

   logic [3:0]  w_in_flags;
   logic        w_full;
   logic        w_empty;
   logic        w_bypass;
   logic        w_push;
   logic        w_pop;

   // Carry is meaningless for logic ops, so it is masked there.
   assign w_in_flags = {carry_out & ~mode, alu_out == 16'h0000,
                        alu_out[15], compare};

   assign w_full  = (r_count == 3'd4);
   assign w_empty = (r_count == 3'd0);

`ifdef ALU_FIFO_BYPASS_EN
   assign w_bypass = w_empty & in_valid;
`else
   assign w_bypass = 1'b0;
`endif

   // A bypassed word taken by the consumer never enters storage.
   assign w_push = in_valid & ~w_full & ~(w_bypass & out_ready);
   assign w_pop  = ~w_empty & out_ready;

   assign in_ready  = ~w_full;
   assign out_valid = ~w_empty | w_bypass;
   assign count     = r_count;

   always_comb begin
      out_data  = 16'h0000;
      out_flags = 4'h0;
      if (!w_empty) begin
         out_data  = r_data[r_rd_ptr];
         out_flags = r_flag[r_rd_ptr];
      end else if (w_bypass) begin
         out_data  = alu_out;
         out_flags = w_in_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_data[r_wr_ptr] <= alu_out;
         r_flag[r_wr_ptr] <= w_in_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr <= 2'd0;
         r_wr_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo.
// Build with ALU_FIFO_BYPASS_EN defined to exercise the bypass path.
module tb_alu_result_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] alu_out;
   logic        carry_out;
   logic        compare;
   logic        mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_flags;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] seq [8];

   alu_result_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_out   (alu_out),
      .carry_out (carry_out),
      .compare   (compare),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [19:0] obs,
                      input logic [19:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] d,
                        input logic c, input logic cm, input logic m,
                        input logic rdy);
      in_valid  = v;
      alu_out   = d;
      carry_out = c;
      compare   = cm;
      mode      = m;
      out_ready = rdy;
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      step();
      rst = 1'b0;
      chk("rst_count", 20'(count), 20'd0);
      chk("rst_out_valid", 20'(out_valid), 20'd0);
      chk("rst_out_data", 20'(out_data), 20'h0);
      chk("rst_out_flags", 20'(out_flags), 20'h0);
      chk("rst_in_ready", 20'(in_ready), 20'd1);

      // zero result, arithmetic, carry set
      drive(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("z_valid", 20'(out_valid), 20'd1);
      chk("z_data", 20'(out_data), 20'h0000);
      chk("z_flags", 20'(out_flags), 20'b1100);
      chk("z_count", 20'(count), 20'd1);
      out_ready = 1'b1;
      step();
      chk("z_pop_count", 20'(count), 20'd0);
      chk("z_pop_valid", 20'(out_valid), 20'd0);

      // logic op masks carry
      drive(1'b1, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b0);
      step();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("m_data", 20'(out_data), 20'h8001);
      chk("m_flags", 20'(out_flags), 20'b0011);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("m_empty_data", 20'(out_data), 20'h0);
      chk("m_empty_flags", 20'(out_flags), 20'h0);

      // fill to full, fifth word dropped
      seq[0] = 16'h0011; seq[1] = 16'h8022;
      seq[2] = 16'h0033; seq[3] = 16'h0044;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, seq[i], 1'b0, 1'b0, 1'b0, 1'b0);
         step();
         chk($sformatf("fill_count%0d", i), 20'(count), 20'(i + 1));
      end
      chk("full_in_ready", 20'(in_ready), 20'd0);
      drive(1'b1, 16'h0055, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk("full5_count", 20'(count), 20'd4);
      chk("full5_hold_data", 20'(out_data), 20'h0011);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("drain_data%0d", i), 20'(out_data), 20'(seq[i]));
         if (i == 1)
            chk("drain_flags1", 20'(out_flags), 20'b0010);
         step();
      end
      chk("drain_count", 20'(count), 20'd0);
      chk("drain_valid", 20'(out_valid), 20'd0);

      // full with push and pop together: pop only
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 16'h0999, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      chk("fullpp_count", 20'(count), 20'd3);
      in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         chk($sformatf("fullpp_data%0d", i), 20'(out_data),
             20'(16'h0100 + 16'(i)));
         step();
      end
      chk("fullpp_empty", 20'(count), 20'd0);

      // steady count=2 with pointer wrap
      for (int i = 0; i < 8; i++) seq[i] = 16'h1000 + 16'(i * 16'h0111);
      drive(1'b1, seq[0], 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      alu_out = seq[1];
      step();
      chk("pp_pre_count", 20'(count), 20'd2);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         alu_out = seq[i + 2];
         chk($sformatf("pp_data%0d", i), 20'(out_data), 20'(seq[i]));
         step();
         chk($sformatf("pp_count%0d", i), 20'(count), 20'd2);
      end
      in_valid = 1'b0;
      for (int i = 6; i < 8; i++) begin
         chk($sformatf("pp_tail%0d", i), 20'(out_data), 20'(seq[i]));
         step();
      end
      chk("pp_end_count", 20'(count), 20'd0);

      // reset mid-operation
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
         step();
      end
      chk("mr_pre_count", 20'(count), 20'd3);
      rst = 1'b1;
      drive(1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0, 1'b1);
      step();
      rst = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("mr_count", 20'(count), 20'd0);
      chk("mr_valid", 20'(out_valid), 20'd0);
      chk("mr_in_ready", 20'(in_ready), 20'd1);
      chk("mr_data", 20'(out_data), 20'h0);
      drive(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("mr_new_data", 20'(out_data), 20'h5A5A);
      chk("mr_new_count", 20'(count), 20'd1);
      step();
      chk("mr_final_count", 20'(count), 20'd0);
      chk("mr_final_valid", 20'(out_valid), 20'd0);

      // bypass probe on empty FIFO
      drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
`ifdef ALU_FIFO_BYPASS_EN
      chk("byp_valid", 20'(out_valid), 20'd1);
      chk("byp_data", 20'(out_data), 20'h1234);
      chk("byp_flags", 20'(out_flags), 20'b0000);
      step();
      chk("byp_count", 20'(count), 20'd0);
`else
      chk("nobyp_valid", 20'(out_valid), 20'd0);
      chk("nobyp_data", 20'(out_data), 20'h0);
      step();
      chk("nobyp_count", 20'(count), 20'd1);
      in_valid = 1'b0;
      chk("nobyp_late_data", 20'(out_data), 20'h1234);
      step();
      chk("nobyp_end_count", 20'(count), 20'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
